// File: rtl/mem_stage.sv
// MEM stage of the 5-stage ARM pipeline: word-addressed data memory plus the
// MEM/WB pipeline register that feeds the write-back mux.
module mem_stage #(
  parameter int MEM_DEPTH = 64,
  parameter int BASE_ADDR = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        wb_enable_in,
  input  logic        mem_read_enable_in,
  input  logic        mem_write_enable_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_value_in,
  input  logic [3:0]  wb_dest_in,
  output logic        wb_enable_out,
  output logic        mem_read_enable_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] data_memory_out,
  output logic [3:0]  wb_dest_out,
  output logic        addr_fault
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [31:0]      mem [MEM_DEPTH];
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             mem_access;

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
  assign offset     = alu_result_in - 32'(BASE_ADDR);
  assign idx        = offset[IDX_W+1:2];
  assign in_range   = offset < 32'(MEM_DEPTH * 4);
  assign mem_access = mem_read_enable_in | mem_write_enable_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_enable_out       <= 1'b0;
      mem_read_enable_out <= 1'b0;
      alu_result_out      <= 32'd0;
      data_memory_out     <= 32'd0;
      wb_dest_out         <= 4'd0;
      addr_fault          <= 1'b0;
    end else if (!freeze) begin
      wb_enable_out       <= wb_enable_in;
      mem_read_enable_out <= mem_read_enable_in;
      alu_result_out      <= alu_result_in;
      wb_dest_out         <= wb_dest_in;
      data_memory_out     <= (mem_read_enable_in && in_range) ? mem[idx] : 32'd0;
      addr_fault          <= mem_access & ~in_range;
    end
  end

  // Reset clears every word so a fresh program always sees zeroed data memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (!freeze && mem_write_enable_in && in_range) begin
      mem[idx] <= store_value_in;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a byte-address reference model pushes the
// expected MEM/WB fields into a queue, popped and compared one cycle later.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        wb_enable_in;
  logic        mem_read_enable_in;
  logic        mem_write_enable_in;
  logic [31:0] alu_result_in;
  logic [31:0] store_value_in;
  logic [3:0]  wb_dest_in;
  logic        wb_enable_out;
  logic        mem_read_enable_out;
  logic [31:0] alu_result_out;
  logic [31:0] data_memory_out;
  logic [3:0]  wb_dest_out;
  logic        addr_fault;

  typedef struct packed {
    logic        wb;
    logic        rd;
    logic [31:0] alu;
    logic [31:0] data;
    logic [3:0]  dest;
    logic        fault;
  } exp_t;

  exp_t        scoreboard[$];
  exp_t        held;
  logic [31:0] model_mem [64];
  int          checks = 0;
  int          passed = 0;

  mem_stage #(.MEM_DEPTH(64), .BASE_ADDR(1024)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .freeze              (freeze),
    .wb_enable_in        (wb_enable_in),
    .mem_read_enable_in  (mem_read_enable_in),
    .mem_write_enable_in (mem_write_enable_in),
    .alu_result_in       (alu_result_in),
    .store_value_in      (store_value_in),
    .wb_dest_in          (wb_dest_in),
    .wb_enable_out       (wb_enable_out),
    .mem_read_enable_out (mem_read_enable_out),
    .alu_result_out      (alu_result_out),
    .data_memory_out     (data_memory_out),
    .wb_dest_out         (wb_dest_out),
    .addr_fault          (addr_fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic checkAll(input string tag, input exp_t e);
    checkOutput({tag, ".wb"},    32'(wb_enable_out),       32'(e.wb));
    checkOutput({tag, ".rd"},    32'(mem_read_enable_out), 32'(e.rd));
    checkOutput({tag, ".alu"},   alu_result_out,           e.alu);
    checkOutput({tag, ".data"},  data_memory_out,          e.data);
    checkOutput({tag, ".dest"},  32'(wb_dest_out),         32'(e.dest));
    checkOutput({tag, ".fault"}, 32'(addr_fault),          32'(e.fault));
  endtask

  task automatic clearModel();
    for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;
    held = '0;
  endtask

  // Drive one EXE-side transaction, predict the MEM/WB result, check it after the edge.
  task automatic applyStimulus(input string tag, input logic frz, input logic wb,
                               input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] val, input logic [3:0] dest);
    exp_t e;
    bit   valid;
    int   word;
    freeze              = frz;
    wb_enable_in        = wb;
    mem_read_enable_in  = rd;
    mem_write_enable_in = wr;
    alu_result_in       = addr;
    store_value_in      = val;
    wb_dest_in          = dest;
    valid = (addr >= 32'd1024) && (addr < 32'd1280);
    word  = valid ? int'((addr - 32'd1024) >> 2) : 0;
    if (frz) begin
      e = held;
    end else begin
      e.wb    = wb;
      e.rd    = rd;
      e.alu   = addr;
      e.dest  = dest;
      e.data  = (rd && valid) ? model_mem[word] : 32'd0;
      e.fault = (rd || wr) && !valid;
      if (wr && valid) model_mem[word] = val;
      held = e;
    end
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    checkAll(tag, scoreboard.pop_front());
  endtask

  // Raise reset between edges and expect the outputs to clear without a clock.
  task automatic asyncReset(input string tag);
    exp_t zero;
    zero = '0;
    rst  = 1'b1;
    #1;
    checkAll(tag, zero);
    clearModel();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    freeze = 1'b0; wb_enable_in = 1'b0; mem_read_enable_in = 1'b0;
    mem_write_enable_in = 1'b0; alu_result_in = 32'd0; store_value_in = 32'd0;
    wb_dest_in = 4'd0;
    rst = 1'b0;
    clearModel();
    asyncReset("por");

    applyStimulus("str_cafe",  0, 0, 0, 1, 32'd1024, 32'h0000CAFE, 4'd0);
    applyStimulus("ldr_cafe",  0, 1, 1, 0, 32'd1024, 32'd0,        4'd5);
    // Leave a store pending when reset lands mid-cycle; it must not stick.
    freeze = 1'b0; mem_write_enable_in = 1'b1; mem_read_enable_in = 1'b0;
    alu_result_in = 32'd1024; store_value_in = 32'h0BADF00D;
    #2;
    asyncReset("mid_rst");
    applyStimulus("ldr_after_rst", 0, 1, 1, 0, 32'd1024, 32'd0, 4'd1);

    applyStimulus("str_dead",  0, 0, 0, 1, 32'd1028, 32'hDEADBEEF, 4'd0);
    applyStimulus("ldr_dead",  0, 1, 1, 0, 32'd1028, 32'd0,        4'd7);
    applyStimulus("str_mis",   0, 0, 0, 1, 32'd1030, 32'h12345678, 4'd0);
    applyStimulus("ldr_mis",   0, 1, 1, 0, 32'd1028, 32'd0,        4'd8);
    applyStimulus("str_last",  0, 0, 0, 1, 32'd1276, 32'h0F0F0F0F, 4'd0);
    applyStimulus("ldr_last",  0, 1, 1, 0, 32'd1276, 32'd0,        4'd9);
    applyStimulus("ldr_1280",  0, 1, 1, 0, 32'd1280, 32'd0,        4'd2);
    applyStimulus("ldr_1020",  0, 1, 1, 0, 32'd1020, 32'd0,        4'd2);
    applyStimulus("str_oob",   0, 0, 0, 1, 32'd1280, 32'h55555555, 4'd0);
    applyStimulus("ldr_first", 0, 1, 1, 0, 32'd1024, 32'd0,        4'd3);

    applyStimulus("alu_add",   0, 1, 0, 0, 32'd7,    32'd0,        4'd3);
    for (int i = 0; i < 3; i++)
      applyStimulus("frz_str", 1, 0, 0, 1, 32'd1032, 32'h000000AA, 4'd0);
    applyStimulus("rel_str",   0, 0, 0, 1, 32'd1032, 32'h000000AA, 4'd0);
    applyStimulus("ldr_aa",    0, 1, 1, 0, 32'd1032, 32'd0,        4'd4);
    for (int i = 0; i < 2; i++)
      applyStimulus("frz_drop", 1, 0, 0, 1, 32'd1040, 32'h00000077, 4'd0);
    applyStimulus("ldr_drop",  0, 1, 1, 0, 32'd1040, 32'd0,        4'd6);

    applyStimulus("str_11",    0, 0, 0, 1, 32'd1036, 32'h00000011, 4'd0);
    applyStimulus("rdwr",      0, 1, 1, 1, 32'd1036, 32'h00000022, 4'd10);
    applyStimulus("ldr_22",    0, 1, 1, 0, 32'd1036, 32'd0,        4'd11);
    applyStimulus("rdwr_oob",  0, 1, 1, 1, 32'hFFFFFFFC, 32'h1, 4'd12);
    for (int i = 0; i < 6; i++)
      applyStimulus("rand", 0, 1'($urandom), 1, 0, 32'd1024 + 32'($urandom_range(0, 15)) * 4,
                    32'd0, 4'($urandom));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage ARM pipeline, between EXE and WB.
- Holds the word-addressed data memory and executes loads and stores.
- Registers the MEM/WB pipeline fields (wb enable, load select, ALU result, loaded data, destination) that feed the write-back mux.
- Supports a pipeline freeze (hazard unit / stall) and flags out-of-range data accesses.

Parameters:
- MEM_DEPTH, 64, number of 32-bit words in data memory (power of two).
- BASE_ADDR, 1024, byte address mapped to word 0.

Ports:
- clk, input, 1, pipeline clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- freeze, input, 1, 1 = hold all state, suppress stores.
- wb_enable_in, input, 1, instruction writes a register.
- mem_read_enable_in, input, 1, instruction is a load (LDR).
- mem_write_enable_in, input, 1, instruction is a store (STR).
- alu_result_in, input, 32, effective byte address, or ALU result for non-memory ops.
- store_value_in, input, 32, Rd value to store.
- wb_dest_in, input, 4, destination register index.
- wb_enable_out, output, 1, registered wb_enable_in.
- mem_read_enable_out, output, 1, registered mem_read_enable_in (WB mux select).
- alu_result_out, output, 32, registered alu_result_in.
- data_memory_out, output, 32, registered load data.
- wb_dest_out, output, 4, registered wb_dest_in.
- addr_fault, output, 1, registered; 1 = previous load/store was out of range.

Behaviour:
- Index calculation:
  - offset = alu_result_in - BASE_ADDR (32-bit, wraps).
  - idx = offset[log2(MEM_DEPTH)+1 : 2].
  - in_range = offset < MEM_DEPTH*4 (unsigned).
  - offset[1:0] is ignored: word access, no alignment fault.
- Asynchronous reset (rst=1, any time, including mid-store):
  - All outputs are 0.
  - All MEM_DEPTH memory words are cleared to 0.
  - Reset overrides freeze.
- Rising clk with rst=0 and freeze=1:
  - Every output register and every memory word holds.
  - No store is performed.
- Rising clk with rst=0 and freeze=0:
  - Pipeline fields: wb_enable_out, mem_read_enable_out, alu_result_out and wb_dest_out load their _in values.
  - Store: if mem_write_enable_in=1 and in_range, mem[idx] <= store_value_in. If out of range, no memory change.
  - Load: data_memory_out <= mem[idx] (pre-write contents) when mem_read_enable_in=1 and in_range; otherwise data_memory_out <= 0.
  - addr_fault <= (mem_read_enable_in | mem_write_enable_in) & ~in_range.
- Latency: exactly 1 cycle from EXE inputs to MEM/WB outputs. A store is visible to a load in the next cycle (store at cycle N, load at N+1 returns the new value).
- Simultaneous read and write enables (illegal encoding):
  - The store is performed.
  - data_memory_out returns the old word.
  - addr_fault is computed as above.
- Out-of-range load: wb_enable_out still passes through. The WB stage writes 0; the fault flag is for the exception/debug logic.
- Address wrap: alu_result_in < BASE_ADDR makes offset wrap to a large value, so out of range.
- Non-memory instruction: memory untouched, data_memory_out = 0, addr_fault = 0.

Test Plan:
- Reset: hold rst=1 mid-cycle with mem_write_enable_in=1 → all outputs 0 immediately (async); a subsequent load from 1024 returns 0.
- Store/load: STR 0xDEADBEEF to 1028; next cycle LDR 1028 → data_memory_out=0xDEADBEEF, mem_read_enable_out=1, wb_dest_out matches, addr_fault=0.
- Misalignment and boundaries:
  - Store 0x12345678 to 1030, load 1028 → 0x12345678 (low bits ignored).
  - Load 1024+252 (last word) is valid.
  - Load 1280 and load 1020 → data=0, addr_fault=1.
- Freeze:
  - freeze=1 for 3 cycles with a pending STR 0xAA to 1032 → outputs unchanged and mem[2] unchanged.
  - Release freeze → store happens on the first unfrozen edge.
- ALU pass-through: ADD result 0x00000007 with wb_enable_in=1, dest 4'd3 → alu_result_out=7, wb_enable_out=1, wb_dest_out=3, data_memory_out=0, addr_fault=0.
- Read+write both set at 1036 holding 0x11 with store 0x22 → data_memory_out=0x11; next load → 0x22.
